// File: rtl/accel_host_driver.sv
// Host-side initiator for the lane accelerator. Per frame: optional soft reset, image load, o_valid poll, map readout.
// Bus cycles issue one cycle after their trigger. s_ready is registered. m_valid holds until m_ready, with one read in flight.
module accel_host_driver #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int IN_BYTES       = 393216,
  parameter int OUT_BYTES      = 2048,
  parameter int OFFSET_INPUT   = 0,
  parameter int OFFSET_OUTPUT  = 393216,
  parameter int OFFSET_OVALID  = 395264,
  parameter int OFFSET_RESET   = 395272,
  parameter int POLL_INTERVAL  = 16,
  parameter int TIMEOUT_POLLS  = 65535,
  parameter int RST_WAIT       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      do_soft_reset,
  input  logic [31:0]               s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [31:0]               m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr,
  output logic [31:0]               axi_wr_data,
  output logic [3:0]                axi_wr_strobe,
  output logic                      axi_wr_en,
  output logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr,
  output logic                      axi_rd_en,
  input  logic [31:0]               axi_rd_data
);

  localparam int IN_WORDS  = IN_BYTES / 4;
  localparam int OUT_WORDS = OUT_BYTES / 4;
  localparam int KW = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
  localparam int JW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int PW = $clog2(TIMEOUT_POLLS + 1);
  localparam int TW = $clog2(POLL_INTERVAL);
  localparam int WW = $clog2(RST_WAIT + 1);

  localparam logic [AXI_ADDR_WIDTH-1:0] A_IN     = AXI_ADDR_WIDTH'(OFFSET_INPUT);
  localparam logic [AXI_ADDR_WIDTH-1:0] A_OUT    = AXI_ADDR_WIDTH'(OFFSET_OUTPUT);
  localparam logic [AXI_ADDR_WIDTH-1:0] A_OVALID = AXI_ADDR_WIDTH'(OFFSET_OVALID);
  localparam logic [AXI_ADDR_WIDTH-1:0] A_RST    = AXI_ADDR_WIDTH'(OFFSET_RESET);

  typedef enum logic [2:0] {IDLE, SRST, RWAIT, LOAD, POLL, READ} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [JW-1:0] j;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] timer;
  logic [WW-1:0] wait_cnt;
  logic          rd_sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= '0;
      j             <= '0;
      poll_cnt      <= '0;
      timer         <= '0;
      wait_cnt      <= '0;
      rd_sample     <= 1'b0;
      s_ready       <= 1'b0;
      m_data        <= '0;
      m_valid       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      axi_wr_addr   <= '0;
      axi_wr_data   <= '0;
      axi_wr_strobe <= '0;
      axi_wr_en     <= 1'b0;
      axi_rd_addr   <= '0;
      axi_rd_en     <= 1'b0;
    end else begin
      axi_wr_en <= 1'b0;
      axi_rd_en <= 1'b0;
      done      <= 1'b0;
      // read data is valid exactly one cycle after the read strobe
      rd_sample <= axi_rd_en;
      case (state)
        IDLE: if (start) begin
          error    <= 1'b0;
          busy     <= 1'b1;
          k        <= '0;
          j        <= '0;
          poll_cnt <= '0;
          timer    <= '0;
          wait_cnt <= '0;
          if (do_soft_reset) state <= SRST;
          else begin
            state   <= LOAD;
            s_ready <= 1'b1;
          end
        end
        SRST: begin
          axi_wr_en     <= 1'b1;
          axi_wr_addr   <= A_RST;
          axi_wr_data   <= 32'd1;
          axi_wr_strobe <= 4'b0001;
          state         <= RWAIT;
        end
        RWAIT: begin
          if (wait_cnt == WW'(RST_WAIT)) begin
            state   <= LOAD;
            s_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        LOAD: if (s_valid && s_ready) begin
          axi_wr_en     <= 1'b1;
          axi_wr_addr   <= A_IN + AXI_ADDR_WIDTH'({k, 2'b00});
          axi_wr_data   <= s_data;
          axi_wr_strobe <= 4'hF;
          k             <= k + KW'(1);
          if (k == KW'(IN_WORDS - 1)) begin
            s_ready <= 1'b0;
            state   <= POLL;
          end
        end
        POLL: begin
          timer <= (timer == TW'(POLL_INTERVAL - 1)) ? '0 : timer + TW'(1);
          if (rd_sample) begin
            if (axi_rd_data[0]) begin
              state       <= READ;
              axi_rd_en   <= 1'b1;
              axi_rd_addr <= A_OUT;
            end else if (poll_cnt == PW'(TIMEOUT_POLLS - 1)) begin
              error <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              poll_cnt <= poll_cnt + PW'(1);
            end
          end else if (timer == TW'(POLL_INTERVAL - 1)) begin
            axi_rd_en   <= 1'b1;
            axi_rd_addr <= A_OVALID;
          end
        end
        READ: begin
          if (rd_sample) begin
            m_data  <= axi_rd_data;
            m_valid <= 1'b1;
          end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            if (j == JW'(OUT_WORDS - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              j           <= j + JW'(1);
              axi_rd_en   <= 1'b1;
              axi_rd_addr <= A_OUT + AXI_ADDR_WIDTH'({(j + JW'(1)), 2'b00});
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_host_driver.sv
// Directed bench for accel_host_driver with a small frame, a register/BRAM model on the read port and a scoreboard.
module tb_accel_host_driver;

  localparam int AW      = 20;
  localparam int IN_B    = 64;
  localparam int OUT_B   = 32;
  localparam int NW      = IN_B / 4;
  localparam int NO      = OUT_B / 4;
  localparam int OFF_OUT = 393216;
  localparam int OFF_OV  = 395264;
  localparam int OFF_RST = 395272;
  localparam int TPOLLS  = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          do_soft_reset;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] axi_wr_addr;
  logic [31:0]   axi_wr_data;
  logic [3:0]    axi_wr_strobe;
  logic          axi_wr_en;
  logic [AW-1:0] axi_rd_addr;
  logic          axi_rd_en;
  logic [31:0]   axi_rd_data;

  accel_host_driver #(
    .AXI_ADDR_WIDTH(AW),
    .IN_BYTES(IN_B),
    .OUT_BYTES(OUT_B),
    .TIMEOUT_POLLS(TPOLLS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .do_soft_reset(do_soft_reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .error(error),
    .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data), .axi_wr_strobe(axi_wr_strobe),
    .axi_wr_en(axi_wr_en), .axi_rd_addr(axi_rd_addr), .axi_rd_en(axi_rd_en),
    .axi_rd_data(axi_rd_data)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
    int            cyc;
  } txn_t;

  txn_t        wq[$];
  txn_t        rq[$];
  logic [31:0] rx_q[$];
  int          poll_cyc[$];
  int          out_addr[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol_both = 0;
  int viol_rdv = 0;
  int viol_stab = 0;
  int done_cnt = 0;
  int ovalid_after = 0;
  int poll_idx = 0;
  int sink_mode = 0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bram_word(input int idx);
    return 32'hCAFE0000 ^ (idx * 32'h00010203);
  endfunction

  // Accelerator register file: o_valid rises after ovalid_after polls, output window is a fixed pattern.
  always @(posedge clk) begin
    if (start) poll_idx <= 0;
    if (axi_rd_en) begin
      if (int'(axi_rd_addr) == OFF_OV) begin
        axi_rd_data <= {31'b0, (poll_idx >= ovalid_after)};
        poll_idx    <= poll_idx + 1;
      end else begin
        axi_rd_data <= bram_word((int'(axi_rd_addr) - OFF_OUT) / 4);
      end
    end
  end

  always @(negedge clk) begin
    if (axi_wr_en) wq.push_back('{axi_wr_addr, axi_wr_data, axi_wr_strobe, cyc});
    if (axi_rd_en) rq.push_back('{axi_rd_addr, 32'd0, 4'd0, cyc});
    if (axi_wr_en && axi_rd_en) viol_both <= viol_both + 1;
    if (axi_rd_en && m_valid) viol_rdv <= viol_rdv + 1;
    if (m_valid && m_ready) rx_q.push_back(m_data);
    if (pv && !pr && (!m_valid || m_data !== pd)) viol_stab <= viol_stab + 1;
    if (done) done_cnt <= done_cnt + 1;
    pv <= m_valid;
    pr <= m_ready;
    pd <= m_data;
  end

  // Sink: always ready, or toggling with one 20-cycle stall once three words have arrived.
  initial begin : sink
    int  stall_left;
    bit  stall_done;
    stall_left = 0;
    stall_done = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sink_mode == 0) m_ready = 1'b1;
      else if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (rx_q.size() == 3 && !stall_done) begin
        m_ready = 1'b0;
        stall_left = 19;
        stall_done = 1;
      end else m_ready = ~m_ready;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic sr);
    @(posedge clk);
    #1;
    start = 1'b1;
    do_soft_reset = sr;
    @(posedge clk);
    #1;
    start = 1'b0;
    do_soft_reset = 1'b0;
  endtask

  task automatic send_words(input int n, input int base);
    int k;
    int guard;
    k = 0;
    guard = 0;
    s_valid = 1'b1;
    s_data = base;
    while (k < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (s_ready) begin
        @(posedge clk);
        #1;
        k++;
        s_data = base + k;
      end
    end
    s_valid = 1'b0;
    check("send_beats", k, n);
  endtask

  task automatic wait_done(input int budget, input int d0);
    int i;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    check("done_seen", (done_cnt != d0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq.delete();
    rq.delete();
    rx_q.delete();
  endtask

  task automatic split_reads();
    poll_cyc.delete();
    out_addr.delete();
    foreach (rq[i]) begin
      if (int'(rq[i].addr) == OFF_OV) poll_cyc.push_back(rq[i].cyc);
      else out_addr.push_back(int'(rq[i].addr));
    end
  endtask

  initial begin : main
    int d0;
    int sr_cyc;
    rst = 1'b1;
    start = 1'b0;
    do_soft_reset = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_wr_en", axi_wr_en, 0);
    check("rst_wr_addr", axi_wr_addr, 0);
    check("rst_rd_en", axi_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_error", error, 0);
    rst = 1'b0;

    // Frame aborted by reset after 10 beats
    pulse_start(1'b0);
    send_words(10, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_s_ready", s_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_wr_en", axi_wr_en, 0);
    check("midrst_wr_data", axi_wr_data, 0);
    rst = 1'b0;
    clear_logs();
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_wr", wq.size(), 0);
    check("no_stale_rd", rq.size(), 0);

    // Plain frame: o_valid after three zero polls, sink always ready
    ovalid_after = 3;
    sink_mode = 0;
    d0 = done_cnt;
    pulse_start(1'b0);
    send_words(NW, 0);
    check("f2_s_ready_low", s_ready, 0);
    wait_done(3000, d0);
    check("f2_done_once", done_cnt - d0, 1);
    check("f2_busy", busy, 0);
    check("f2_error", error, 0);
    check("f2_wr_cnt", wq.size(), NW);
    for (int i = 0; i < wq.size() && i < NW; i++) begin
      check("f2_wr_addr", wq[i].addr, 4 * i);
      check("f2_wr_data", wq[i].data, i);
      check("f2_wr_strb", wq[i].strb, 4'hF);
      check("f2_wr_b2b", wq[i].cyc - wq[0].cyc, i);
    end
    split_reads();
    check("f2_poll_cnt", poll_cyc.size(), 4);
    if (poll_cyc.size() > 0 && wq.size() > 0)
      check("f2_first_poll_gap", poll_cyc[0] - wq[wq.size()-1].cyc, 16);
    for (int i = 1; i < poll_cyc.size(); i++)
      check("f2_poll_spacing", poll_cyc[i] - poll_cyc[i-1], 16);
    check("f2_out_rd_cnt", out_addr.size(), NO);
    for (int i = 0; i < out_addr.size(); i++)
      check("f2_out_rd_addr", out_addr[i], OFF_OUT + 4 * i);
    check("f2_rx_cnt", rx_q.size(), NO);
    for (int i = 0; i < rx_q.size(); i++)
      check("f2_rx_data", rx_q[i], bram_word(i));

    // Soft-reset frame with toggling, stalling sink
    ovalid_after = 0;
    sink_mode = 1;
    clear_logs();
    d0 = done_cnt;
    pulse_start(1'b1);
    for (int i = 0; i < 100 && !s_ready; i++) begin
      @(posedge clk);
      #1;
    end
    sr_cyc = cyc;
    check("f3_s_ready_up", s_ready, 1);
    check("f3_srst_wr_cnt", wq.size(), 1);
    if (wq.size() > 0) begin
      check("f3_srst_addr", wq[0].addr, OFF_RST);
      check("f3_srst_data", wq[0].data, 1);
      check("f3_srst_strb", wq[0].strb, 4'b0001);
      check("f3_srst_gap", sr_cyc - wq[0].cyc, 17);
    end
    check("f3_srst_no_rd", rq.size(), 0);
    send_words(NW, 100);
    wait_done(3000, d0);
    check("f3_done_once", done_cnt - d0, 1);
    check("f3_wr_cnt", wq.size(), NW + 1);
    split_reads();
    check("f3_poll_cnt", poll_cyc.size(), 1);
    check("f3_out_rd_cnt", out_addr.size(), NO);
    check("f3_rx_cnt", rx_q.size(), NO);
    for (int i = 0; i < rx_q.size(); i++)
      check("f3_rx_data", rx_q[i], bram_word(i));
    check("f3_stable_viol", viol_stab, 0);
    check("f3_rd_while_valid", viol_rdv, 0);

    // Timeout frame: o_valid never rises; a start mid-load must be ignored
    ovalid_after = 1000;
    sink_mode = 0;
    clear_logs();
    d0 = done_cnt;
    pulse_start(1'b0);
    send_words(5, 0);
    pulse_start(1'b1);
    check("f4_busy_kept", busy, 1);
    send_words(NW - 5, 5);
    wait_done(2000, d0);
    check("f4_done_once", done_cnt - d0, 1);
    check("f4_error", error, 1);
    check("f4_busy", busy, 0);
    check("f4_m_valid", m_valid, 0);
    check("f4_wr_cnt", wq.size(), NW);
    split_reads();
    check("f4_poll_cnt", poll_cyc.size(), TPOLLS);
    check("f4_out_rd_cnt", out_addr.size(), 0);
    pulse_start(1'b0);
    check("f4_error_cleared", error, 0);
    check("f4_busy_again", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("end_rst_busy", busy, 0);
    rst = 1'b0;
    check("wr_rd_overlap", viol_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accel_host_driver.md
Name: accel_host_driver

Overview:
- Bus initiator that drives the accelerator's simple register interface (wr_en/rd_en, byte address, 32-bit data, 4-bit strobe) from the host side.
- Per frame: optional soft reset, stream the packed RGB image into the input window, poll the o_valid register, then read the 64x32 lane map and emit it as a word stream.
- Sits between a DMA/stream source and the accelerator top; the only master on that interface.

Parameters:
- AXI_ADDR_WIDTH, 20, accelerator byte-address width.
- IN_BYTES, 393216, input image bytes (512x256x3); must be a multiple of 4.
- OUT_BYTES, 2048, output map bytes (64x32).
- OFFSET_INPUT, 0, input window base.
- OFFSET_OUTPUT, 393216, output window base.
- OFFSET_OVALID, 395264, o_valid status register.
- OFFSET_RESET, 395272, soft-reset register.
- POLL_INTERVAL, 16, cycles between o_valid polls (>=2).
- TIMEOUT_POLLS, 65535, polls before abort.
- RST_WAIT, 16, idle cycles after a soft-reset write (>=16).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle frame start pulse; ignored unless idle
- do_soft_reset  in  1  sampled with start; 1 = issue soft reset first
- s_data  in  32  packed image bytes, byte0 at [7:0]
- s_valid  in  1  source valid
- s_ready  out  1  source ready
- m_data  out  32  output map word (4 bytes, byte0 at [7:0])
- m_valid  out  1  output valid
- m_ready  in  1  sink ready
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame complete
- error  out  1  sticky timeout flag; cleared by start or rst
- axi_wr_addr  out  AXI_ADDR_WIDTH  write byte address
- axi_wr_data  out  32  write data
- axi_wr_strobe  out  4  byte strobes
- axi_wr_en  out  1  write strobe
- axi_rd_addr  out  AXI_ADDR_WIDTH  read byte address
- axi_rd_en  out  1  read strobe
- axi_rd_data  in  32  read data; valid the cycle after axi_rd_en

Behaviour:
- Reset (synchronous, rst high at a clk edge): state IDLE; all outputs 0, including addresses, data, strobe, s_ready, m_valid, busy, done and error. Reset mid-frame aborts immediately with no further bus cycles.
- All bus outputs are registered. axi_wr_en and axi_rd_en are single-cycle pulses and are never high together.
- IDLE: on start, clear error, set busy, and go to SRST if do_soft_reset, otherwise LOAD.
- SRST: one write to OFFSET_RESET with data 1 and strobe 4'b0001. Then RWAIT.
- RWAIT: wait RST_WAIT cycles with no bus activity, then LOAD.
- LOAD:
  - s_ready = 1 while in LOAD and not all words have been accepted.
  - Each s_valid&&s_ready beat produces, next cycle, a write of s_data to OFFSET_INPUT+4*k with strobe 4'hF; k counts 0..IN_BYTES/4-1.
  - Back-to-back beats give back-to-back writes.
  - After the beat with k = IN_BYTES/4-1, s_ready drops the same cycle. Go to POLL after that write issues.
- POLL:
  - Every POLL_INTERVAL cycles (first read at entry+POLL_INTERVAL), issue a read at OFFSET_OVALID and sample axi_rd_data[0] the next cycle.
  - If the bit is 1, go to READ.
  - If it is 0, increment the poll counter. When the counter reaches TIMEOUT_POLLS, set error, pulse done, clear busy and go to IDLE with no readout.
- READ:
  - For j = 0..OUT_BYTES/4-1: issue a read at OFFSET_OUTPUT+4*j, then on the next cycle latch axi_rd_data into m_data and set m_valid.
  - Hold m_data and m_valid until m_ready. At most one read is outstanding.
  - The next read issues the cycle after the handshake.
  - After the final handshake: pulse done, clear busy, go to IDLE.
- m_valid never depends on m_ready. m_data stays stable while m_valid&&!m_ready.
- start while busy is ignored. s_valid outside LOAD is ignored (s_ready=0).
- Counters are sized with $clog2 of their range. Address arithmetic is modulo 2^AXI_ADDR_WIDTH.

Test Plan:
- Reset mid-LOAD (after 10 beats), then start with do_soft_reset=0 -> all outputs 0 after rst; the new frame's first write is at addr 0, with no stale writes.
- start with do_soft_reset=1 -> exactly one write (addr 395272, data 1, strobe 0001), 16 idle cycles, then s_ready=1.
- Continuous s_valid of 98304 words with s_data=k -> 98304 consecutive writes, addr 4k, data k, strobe F; s_ready low after the last beat; first poll read 16 cycles later.
- o_valid model returns 0 for 3 polls then 1 -> reads at 395264 spaced 16 cycles; 512 output reads at 393216..395260; m_data matches the model BRAM; done pulses once after the 512th handshake.
- m_ready toggling 1/0 every cycle plus a 20-cycle stall -> no lost or duplicated words; m_data stable during stalls; no new axi_rd_en while m_valid&&!m_ready.
- TIMEOUT_POLLS=4 with o_valid stuck at 0 -> 4 polls, then error=1, one done pulse, busy=0, no reads at OFFSET_OUTPUT; start while busy has no effect.
